// File: rtl/change_payout_ctrl_pkg.sv
// rtl/change_payout_ctrl_pkg.sv - shared constants, error codes and payout state encoding
//
// Purpose : Coin values, error-code encoding and the payout FSM state type
//           used by the change payout controller and its timeout counter.
// Contents: COIN5, COIN10      coin values in cents
//           err_code_t         00 none, 01 bad amount, 10 coin shortage, 11 ack timeout
//           payout_state_t     payout FSM states
//           is_mult5()         true when a cent amount can be paid in 5c/10c coins

package change_payout_ctrl_pkg;

    localparam int COIN5  = 5;
    localparam int COIN10 = 10;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_AMT   = 2'b01,
        ERR_SHORT = 2'b10,
        ERR_TMO   = 2'b11
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_CHOOSE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } payout_state_t;

    function automatic logic is_mult5(input logic [31:0] i_amount);
        return (i_amount % 32'd5) == 32'd0;
    endfunction

endpackage

// File: rtl/change_payout_ctrl_if.sv
// rtl/change_payout_ctrl_if.sv - request, hopper and status signals of the change payout controller
//
// Purpose : Bundles the vend-FSM request handshake, the hopper req/ack
//           handshake and the payout status outputs.
// Modports: slave  - the payout controller
//           master - the environment (vend FSM + hopper drivers)
// Signals : req_valid/req_amount/req_ready  change request handshake
//           hi_empty/lo_empty               10c / 5c hopper empty flags
//           hop_hi_req/hop_lo_req/hop_ack   one-coin eject handshake
//           busy/done/err/err_code          status
//           paid_total                      cents paid for current/last request

interface change_payout_ctrl_if #(
    parameter int AMT_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             hi_empty;
    logic             lo_empty;
    logic             hop_hi_req;
    logic             hop_lo_req;
    logic             hop_ack;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [AMT_W-1:0] paid_total;

    modport slave (
        input  req_valid, req_amount, hi_empty, lo_empty, hop_ack,
        output req_ready, hop_hi_req, hop_lo_req, busy, done, err, err_code, paid_total
    );

    modport master (
        output req_valid, req_amount, hi_empty, lo_empty, hop_ack,
        input  req_ready, hop_hi_req, hop_lo_req, busy, done, err, err_code, paid_total
    );

endinterface

// File: rtl/change_payout_ctrl_tmo.sv
// rtl/change_payout_ctrl_tmo.sv - hopper acknowledge timeout counter
//
// Purpose : Counts cycles spent waiting for a hopper acknowledge.
// Ports   : clk        clock
//           rst        asynchronous reset, active-high
//           i_clr      restart the count (asserted when a coin request is issued)
//           i_en       count this cycle (controller is waiting for ack)
//           o_expired  high during the ACK_TIMEOUT-th enabled cycle since i_clr

module change_payout_ctrl_tmo #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TMO_W-1:0] r_cnt;
    logic             w_at_limit;

    // The count holds the number of already-elapsed waiting cycles, so the
    // limit is one below ACK_TIMEOUT: the request then stays high for exactly
    // ACK_TIMEOUT cycles before the controller gives up.
    assign w_at_limit = (r_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign o_expired  = i_en && w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/change_payout_ctrl.sv
// rtl/change_payout_ctrl.sv - coin hopper sequencer that pays out change in 10c and 5c coins
//
// Purpose : Accepts one change request, ejects 10c coins while they fit and
//           are available, falls back to 5c coins, and reports done or an
//           error together with the amount actually paid.
// Ports   : clk   clock
//           rst   asynchronous reset, active-high
//           bus   change_payout_ctrl_if.slave (request, hopper and status signals)
// Params  : AMT_W        width of amount/paid fields in cents
//           ACK_TIMEOUT  cycles a hopper request may wait for ack
//           TMO_W        width of the timeout counter

module change_payout_ctrl
    import change_payout_ctrl_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    change_payout_ctrl_if.slave    bus
);

    localparam logic [AMT_W-1:0] C5  = AMT_W'(COIN5);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(COIN10);

    payout_state_t    r_state;
    payout_state_t    w_next;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] r_paid;
    err_code_t        r_err_code;
    logic             r_hop_hi_req;
    logic             r_hop_lo_req;

    logic             w_accept;
    logic             w_take_hi;
    logic             w_take_lo;
    logic             w_ack;
    logic             w_tmo;
    logic             w_err_set;
    err_code_t        w_err_val;
    logic             w_expired;
    logic [AMT_W-1:0] w_coin;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // Only one hopper request is ever outstanding, so the raised request
    // identifies the coin being paid.
    assign w_coin = r_hop_hi_req ? C10 : C5;

    change_payout_ctrl_tmo #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_take_hi || w_take_lo),
        .i_en      (r_state == ST_WAIT_ACK),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_take_hi = 1'b0;
        w_take_lo = 1'b0;
        w_ack     = 1'b0;
        w_tmo     = 1'b0;
        w_err_set = 1'b0;
        w_err_val = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!is_mult5(32'(r_remaining))) begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_AMT;
                end else begin
                    w_next = ST_CHOOSE;
                end
            end
            ST_CHOOSE: begin
                // One coin decision per visit; a missing 10c coin is covered
                // by two consecutive 5c decisions.
                if (r_remaining == '0) begin
                    w_next = ST_DONE;
                end else if ((r_remaining >= C10) && !bus.hi_empty) begin
                    w_next    = ST_WAIT_ACK;
                    w_take_hi = 1'b1;
                end else if ((r_remaining >= C5) && !bus.lo_empty) begin
                    w_next    = ST_WAIT_ACK;
                    w_take_lo = 1'b1;
                end else begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_SHORT;
                end
            end
            ST_WAIT_ACK: begin
                // An ack arriving in the expiry cycle still counts as a coin.
                if (bus.hop_ack) begin
                    w_next = ST_CHOOSE;
                    w_ack  = 1'b1;
                end else if (w_expired) begin
                    w_next    = ST_ERR;
                    w_tmo     = 1'b1;
                    w_err_set = 1'b1;
                    w_err_val = ERR_TMO;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // remaining and paid move together so paid_total always equals
    // req_amount - remaining, including the partial payout on an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_paid      <= '0;
            r_err_code  <= ERR_NONE;
        end else begin
            if (w_accept) begin
                r_remaining <= bus.req_amount;
                r_paid      <= '0;
                r_err_code  <= ERR_NONE;
            end else if (w_ack) begin
                r_remaining <= r_remaining - w_coin;
                r_paid      <= r_paid + w_coin;
            end
            if (w_err_set) begin
                r_err_code <= w_err_val;
            end
        end
    end

    // Hopper requests are registered: raised on entry to WAIT_ACK, dropped the
    // cycle after ack or timeout, which guarantees a low cycle between coins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hop_hi_req <= 1'b0;
            r_hop_lo_req <= 1'b0;
        end else begin
            if (w_ack || w_tmo) begin
                r_hop_hi_req <= 1'b0;
                r_hop_lo_req <= 1'b0;
            end else begin
                if (w_take_hi) begin
                    r_hop_hi_req <= 1'b1;
                end
                if (w_take_lo) begin
                    r_hop_lo_req <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_ERR);
    assign bus.err_code   = r_err_code;
    assign bus.paid_total = r_paid;
    assign bus.hop_hi_req = r_hop_hi_req;
    assign bus.hop_lo_req = r_hop_lo_req;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// tb/tb_change_payout_ctrl.sv - self-checking bench for change_payout_ctrl

module tb_change_payout_ctrl;
    import change_payout_ctrl_pkg::*;

    localparam int AMT_W       = 8;
    localparam int ACK_TIMEOUT = 255;
    localparam int CYC_BUDGET  = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    change_payout_ctrl_if #(.AMT_W(AMT_W)) bus_if ();

    change_payout_ctrl #(
        .AMT_W       (AMT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMO_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // hopper environment
    int hi_stock  = 0;
    int lo_stock  = 0;
    int ack_delay = 1;
    int tmo_at    = -1;
    int coin_idx  = 0;
    bit noise_en  = 1'b0;
    int got_coins[$];

    assign bus_if.hi_empty = (hi_stock == 0);
    assign bus_if.lo_empty = (lo_stock == 0);

    // reference expectations
    int exp_coins[$];
    int exp_done, exp_code, exp_paid, exp_first;

    // Greedy payout from the rules: largest coin that fits and is in stock.
    task automatic model(input int amt, input int hi, input int lo, input int tmo);
        int rem, coin, idx;
        exp_coins.delete();
        exp_paid = 0;
        if (amt % 5 != 0) begin
            exp_done = 0; exp_code = 1; exp_first = 2;
            return;
        end
        exp_first = 3;
        rem = amt;
        idx = 0;
        forever begin
            if (rem == 0) begin exp_done = 1; exp_code = 0; break; end
            if (rem >= 10 && hi > 0) coin = 10;
            else if (rem >= 5 && lo > 0) coin = 5;
            else begin exp_done = 0; exp_code = 2; break; end
            if (idx == tmo) begin exp_done = 0; exp_code = 3; break; end
            exp_coins.push_back(coin);
            rem -= coin;
            exp_paid += coin;
            if (coin == 10) hi--; else lo--;
            idx++;
        end
    endtask

    // Hopper driver: acks the ack_delay-th cycle of each request, never acks
    // coin number tmo_at, optionally emits stray acks while no request is up.
    initial begin
        int cnt;
        bit real_prev;
        bit req;
        cnt = 0;
        real_prev = 1'b0;
        bus_if.hop_ack = 1'b0;
        forever begin
            @(negedge clk);
            req = bus_if.hop_hi_req | bus_if.hop_lo_req;
            if (rst) begin
                cnt = 0;
                real_prev = 1'b0;
                bus_if.hop_ack = 1'b0;
            end else begin
                if (real_prev) check("req_drop_after_ack", int'(req), 0);
                real_prev = 1'b0;
                if (req) begin
                    check("one_req_only", int'(bus_if.hop_hi_req & bus_if.hop_lo_req), 0);
                    cnt++;
                    if (coin_idx != tmo_at && cnt == ack_delay) begin
                        bus_if.hop_ack = 1'b1;
                        real_prev = 1'b1;
                        if (bus_if.hop_hi_req) begin got_coins.push_back(10); hi_stock--; end
                        else begin got_coins.push_back(5); lo_stock--; end
                        coin_idx++;
                        cnt = 0;
                    end else begin
                        bus_if.hop_ack = 1'b0;
                    end
                end else begin
                    if (cnt > 0 && coin_idx == tmo_at) check("tmo_req_cycles", cnt, ACK_TIMEOUT);
                    cnt = 0;
                    bus_if.hop_ack = noise_en && ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    task automatic run_req(input int amt, input int hi, input int lo, input int dly,
                           input int tmo, input bit poke);
        int first, end_cyc;
        bit saw_done, saw_err;
        @(negedge clk);
        hi_stock  = hi;
        lo_stock  = lo;
        ack_delay = dly;
        tmo_at    = tmo;
        coin_idx  = 0;
        got_coins.delete();
        model(amt, hi, lo, tmo);
        check("req_ready_idle", int'(bus_if.req_ready), 1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_amount = AMT_W'(amt);
        first = -1; end_cyc = 0; saw_done = 0; saw_err = 0;
        for (int c = 1; c <= CYC_BUDGET; c++) begin
            @(negedge clk);
            bus_if.req_valid = poke && (c == 2);
            if (poke && c == 2) bus_if.req_amount = AMT_W'($urandom_range(0, 255));
            if (first < 0 && (bus_if.hop_hi_req || bus_if.hop_lo_req || bus_if.done || bus_if.err))
                first = c;
            check("busy_in_flight", int'(bus_if.busy), 1);
            if (bus_if.done || bus_if.err) begin
                saw_done = bus_if.done;
                saw_err  = bus_if.err;
                end_cyc  = c;
                break;
            end
        end
        bus_if.req_valid = 1'b0;
        if (end_cyc == 0) check("request_finished", 0, 1);
        check("done_pulse", int'(saw_done), exp_done);
        check("err_pulse", int'(saw_err), 1 - exp_done);
        check("err_code", int'(bus_if.err_code), exp_code);
        check("paid_total", int'(bus_if.paid_total), exp_paid);
        check("first_event_cycle", first, exp_first);
        check("coin_count", got_coins.size(), exp_coins.size());
        for (int i = 0; i < exp_coins.size() && i < got_coins.size(); i++)
            check("coin_value", got_coins[i], exp_coins[i]);
        @(negedge clk);
        check("pulse_one_cycle", int'(bus_if.done | bus_if.err), 0);
        check("ready_after", int'(bus_if.req_ready), 1);
        check("err_code_held", int'(bus_if.err_code), exp_code);
        check("paid_held", int'(bus_if.paid_total), exp_paid);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bus_if.req_valid  = 1'b0;
        bus_if.req_amount = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_req_ready", int'(bus_if.req_ready), 1);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_done_err", int'(bus_if.done | bus_if.err), 0);
        check("rst_err_code", int'(bus_if.err_code), 0);
        check("rst_paid", int'(bus_if.paid_total), 0);
        check("rst_hop_req", int'(bus_if.hop_hi_req | bus_if.hop_lo_req), 0);
        rst = 1'b0;

        run_req(15, 10, 10, 2, -1, 1'b0);           // hi then lo coin
        run_req(20, 0, 10, 2, -1, 1'b0);            // four 5c coins
        run_req(7, 10, 10, 2, -1, 1'b0);            // bad amount
        run_req(0, 10, 10, 2, -1, 1'b0);            // nothing owed
        run_req(10, 0, 1, 2, -1, 1'b0);             // 5c runs out
        run_req(10, 10, 10, 1, 0, 1'b0);            // ack never arrives
        run_req(10, 10, 10, ACK_TIMEOUT, -1, 1'b0); // ack on expiry cycle wins
        run_req(255, 30, 30, 1, -1, 1'b0);          // full-width amount

        noise_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int amt;
            amt = $urandom_range(0, 80);
            if ($urandom_range(0, 3) != 0) amt = 5 * $urandom_range(0, 16);
            run_req(amt, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                    1'($urandom_range(0, 1)));
        end
        noise_en = 1'b0;

        // asynchronous reset while a hopper request is outstanding
        @(negedge clk);
        hi_stock = 5; lo_stock = 5; tmo_at = 0; coin_idx = 0; ack_delay = 1;
        bus_if.req_valid  = 1'b1;
        bus_if.req_amount = AMT_W'(10);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("wait_ack_hi_req", int'(bus_if.hop_hi_req), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hop_req", int'(bus_if.hop_hi_req | bus_if.hop_lo_req), 0);
        check("async_rst_busy", int'(bus_if.busy), 0);
        check("async_rst_ready", int'(bus_if.req_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tmo_at = -1;
        run_req(25, 10, 10, 3, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
